st2_exec: RTL and testbench

Second pipeline stage of the two-stage processor: consumes the registered ALU operands and control fields produced by stage 1 and produces the registered execution result with its flags. Arithmetic, logic and load-pass operations complete in one cycle. Shifts and rotates run on an iterative one-bit-per-cycle shifter and raise `stall` back toward the stage-1 enable logic while they run. The result register feeds the register-file writeback path.

---
 rtl/st2_exec_if.sv | 25 ++
 rtl/st2_exec.sv | 98 +++++++++
 tb/tb_st2_exec.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/st2_exec_if.sv
// st2_exec_if: operand/control bus from stage 1 into st2_exec and its result/flag outputs
//   master: drives aluin1/aluin2/operation_in/opselect_in/enable_*/shift_number, reads results
//   slave : the execute stage
interface st2_exec_if;
  logic [31:0] aluin1;
  logic [31:0] aluin2;
  logic [2:0]  operation_in;
  logic [2:0]  opselect_in;
  logic        enable_arith;
  logic        enable_shift;
  logic [4:0]  shift_number;
  logic [31:0] aluout;
  logic        carry;
  logic        zero;
  logic        result_valid;
  logic        stall;
  modport master (
    output aluin1, aluin2, operation_in, opselect_in, enable_arith, enable_shift, shift_number,
    input  aluout, carry, zero, result_valid, stall
  );
  modport slave (
    input  aluin1, aluin2, operation_in, opselect_in, enable_arith, enable_shift, shift_number,
    output aluout, carry, zero, result_valid, stall
  );
endinterface

// File: rtl/st2_exec.sv
// st2_exec: execute stage with single-cycle ALU/load and an iterative 1-bit-per-cycle shifter
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : st2_exec_if.slave (operands, op/class codes, starts, result, carry/zero, valid, stall)
module st2_exec (
  input logic       clk,
  input logic       reset,
  st2_exec_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t      r_state, w_state;
  logic [31:0] r_acc, w_acc, r_aluout, w_aluout, w_step, w_arith;
  logic [4:0]  r_cnt, w_cnt;
  logic [1:0]  r_type, w_type;
  logic        r_carry, w_carry, r_zero, w_zero, r_valid, w_valid;
  logic [32:0] w_sum, w_diff;
  logic        w_is_alu;
  assign w_sum    = {1'b0, bus.aluin1} + {1'b0, bus.aluin2};
  assign w_diff   = {1'b0, bus.aluin1} - {1'b0, bus.aluin2};
  assign w_is_alu = bus.opselect_in == 3'd1;
  // type[1] selects right-shifts with a fill bit: sign for SRA, wrapped LSB for ROR
  assign w_step = r_type[1] ? {r_type[0] ? r_acc[0] : r_acc[31], r_acc[31:1]} :
                  r_type[0] ? {1'b0, r_acc[31:1]} : {r_acc[30:0], 1'b0};
  always_comb begin
    w_arith = bus.aluin2;
    case (bus.operation_in)
      3'd0: w_arith = w_sum[31:0];
      3'd1: w_arith = w_diff[31:0];
      3'd2: w_arith = bus.aluin1 & bus.aluin2;
      3'd3: w_arith = bus.aluin1 | bus.aluin2;
      3'd4: w_arith = bus.aluin1 ^ bus.aluin2;
      3'd5: w_arith = ~(bus.aluin1 | bus.aluin2);
      3'd6: w_arith = {31'd0, $signed(bus.aluin1) < $signed(bus.aluin2)};
      default: w_arith = bus.aluin2;
    endcase
  end
  always_comb begin
    w_state  = r_state;
    w_acc    = r_acc;
    w_cnt    = r_cnt;
    w_type   = r_type;
    w_aluout = r_aluout;
    w_carry  = r_carry;
    w_valid  = 1'b0;
    if (r_state == SHIFT) begin
      w_acc = w_step;
      w_cnt = r_cnt - 5'd1;
      if (r_cnt == 5'd1) begin
        w_state  = IDLE;
        w_aluout = w_step;
        w_valid  = 1'b1;
      end
    end else if (bus.enable_shift) begin
      // reserved shift codes and zero-distance shifts finish immediately with aluin1
      if (bus.operation_in[2] || bus.shift_number == 5'd0) begin
        w_aluout = bus.aluin1;
        w_valid  = 1'b1;
      end else begin
        w_state = SHIFT;
        w_acc   = bus.aluin1;
        w_cnt   = bus.shift_number;
        w_type  = bus.operation_in[1:0];
      end
    end else if (bus.enable_arith) begin
      w_aluout = w_is_alu ? w_arith : bus.aluin2;
      w_carry  = (w_is_alu && bus.operation_in == 3'd0) ? w_sum[32] :
                 (w_is_alu && bus.operation_in == 3'd1) ? w_diff[32] : r_carry;
      w_valid  = 1'b1;
    end
    w_zero = w_valid ? (w_aluout == 32'd0) : r_zero;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_type   <= '0;
      r_aluout <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_acc    <= w_acc;
      r_cnt    <= w_cnt;
      r_type   <= w_type;
      r_aluout <= w_aluout;
      r_carry  <= w_carry;
      r_zero   <= w_zero;
      r_valid  <= w_valid;
    end
  end
  assign bus.aluout       = r_aluout;
  assign bus.carry        = r_carry;
  assign bus.zero         = r_zero;
  assign bus.result_valid = r_valid;
  assign bus.stall        = r_state == SHIFT;
endmodule

// File: tb/tb_st2_exec.sv
// tb_st2_exec: directed scoreboard bench for st2_exec
module tb_st2_exec;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  st2_exec_if bus();
  st2_exec dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        z;
    int          lat;
    int          stalls;
  } exp_t;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic m_carry = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input string tag, input bit sh, input bit ar, input logic [2:0] sel,
                       input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] n, input bit poke = 1'b0);
    exp_t e;
    logic [31:0] r;
    logic [32:0] w;
    int lat, st;
    r = b;
    e.c = m_carry;
    if (sh) begin
      case (op)
        3'd0: r = a << n;
        3'd1: r = a >> n;
        3'd2: r = $signed(a) >>> n;
        3'd3: r = (a >> n) | (a << (32 - int'(n)));
        default: r = a;
      endcase
    end else if (sel == 3'd1) begin
      case (op)
        3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; e.c = w[32]; end
        3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; e.c = w[32]; end
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: r = ~(a | b);
        3'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: r = b;
      endcase
    end
    e.res = r;
    e.z = (r == 32'd0);
    e.lat = (sh && op < 3'd4 && n != 5'd0) ? int'(n) + 1 : 1;
    e.stalls = e.lat - 1;
    m_carry = e.c;
    sb.push_back(e);
    bus.aluin1 = a;
    bus.aluin2 = b;
    bus.opselect_in = sel;
    bus.operation_in = op;
    bus.shift_number = n;
    bus.enable_shift = sh;
    bus.enable_arith = ar;
    tick;
    bus.enable_shift = 1'b0;
    bus.enable_arith = 1'b0;
    lat = 1;
    st = 0;
    while (!bus.result_valid && lat < 40) begin
      if (bus.stall) st++;
      if (poke && lat == 2) begin
        bus.opselect_in = 3'd1;
        bus.operation_in = 3'd0;
        bus.enable_arith = 1'b1;
      end
      tick;
      bus.enable_arith = 1'b0;
      lat++;
    end
    e = sb.pop_front();
    chk({tag, "_valid"}, {31'd0, bus.result_valid}, 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    chk({tag, "_stalls"}, 32'(st), 32'(e.stalls));
    chk({tag, "_aluout"}, bus.aluout, e.res);
    chk({tag, "_carry"}, {31'd0, bus.carry}, {31'd0, e.c});
    chk({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, e.z});
    tick;
    chk({tag, "_pulse"}, {31'd0, bus.result_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bus.stall}, 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int v;
    bus.aluin1 = '0;
    bus.aluin2 = '0;
    bus.operation_in = '0;
    bus.opselect_in = '0;
    bus.enable_arith = 1'b0;
    bus.enable_shift = 1'b0;
    bus.shift_number = '0;
    repeat (2) tick;
    chk("rst_aluout", bus.aluout, 32'd0);
    chk("rst_carry", {31'd0, bus.carry}, 32'd0);
    chk("rst_zero", {31'd0, bus.zero}, 32'd0);
    chk("rst_valid", {31'd0, bus.result_valid}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    reset = 1'b1;
    tick;
    issue("add_ovf", 1'b0, 1'b1, 3'd1, 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    issue("sub_borrow", 1'b0, 1'b1, 3'd1, 3'd1, 32'd3, 32'd5, 5'd0);
    issue("and_hold_c", 1'b0, 1'b1, 3'd1, 3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
    issue("sub_noborrow", 1'b0, 1'b1, 3'd1, 3'd1, 32'd9, 32'd4, 5'd0);
    issue("slt", 1'b0, 1'b1, 3'd1, 3'd6, 32'h8000_0000, 32'd1, 5'd0);
    issue("slt_false", 1'b0, 1'b1, 3'd1, 3'd6, 32'd1, 32'h8000_0000, 5'd0);
    issue("or", 1'b0, 1'b1, 3'd1, 3'd3, 32'h1200_0034, 32'h0056_7800, 5'd0);
    issue("xor", 1'b0, 1'b1, 3'd1, 3'd4, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0);
    issue("nor", 1'b0, 1'b1, 3'd1, 3'd5, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 5'd0);
    issue("pass_b", 1'b0, 1'b1, 3'd1, 3'd7, 32'h1111_1111, 32'h2468_ACE0, 5'd0);
    issue("load", 1'b0, 1'b1, 3'd5, 3'd0, 32'h1, 32'hDEAD_BEEF, 5'd0);
    issue("other_sel", 1'b0, 1'b1, 3'd3, 3'd1, 32'h7, 32'h0000_0000, 5'd0);
    issue("sll5_poke", 1'b1, 1'b0, 3'd0, 3'd0, 32'h0000_0001, 32'h0, 5'd5, 1'b1);
    issue("sra31", 1'b1, 1'b0, 3'd0, 3'd2, 32'h8000_0000, 32'h0, 5'd31);
    issue("ror1", 1'b1, 1'b0, 3'd0, 3'd3, 32'h0000_0001, 32'h0, 5'd1);
    issue("srl7", 1'b1, 1'b0, 3'd0, 3'd1, 32'h8765_4321, 32'h0, 5'd7);
    issue("ror12", 1'b1, 1'b0, 3'd0, 3'd3, 32'h1234_5678, 32'h0, 5'd12);
    issue("shift0", 1'b1, 1'b0, 3'd0, 3'd0, 32'hCAFE_F00D, 32'h0, 5'd0);
    issue("shift_rsvd", 1'b1, 1'b0, 3'd0, 3'd5, 32'h0BAD_CAFE, 32'h0, 5'd9);
    issue("both_en", 1'b1, 1'b1, 3'd1, 3'd0, 32'h0000_0003, 32'h1, 5'd2);
    issue("add_pre_rst", 1'b0, 1'b1, 3'd1, 3'd0, 32'hFFFF_FFFF, 32'd2, 5'd0);
    bus.aluin1 = 32'hFFFF_0000;
    bus.opselect_in = 3'd0;
    bus.operation_in = 3'd1;
    bus.shift_number = 5'd10;
    bus.enable_shift = 1'b1;
    tick;
    bus.enable_shift = 1'b0;
    tick;
    tick;
    chk("mid_shift_stall", {31'd0, bus.stall}, 32'd1);
    @(posedge clk);
    reset = 1'b0;
    #1;
    chk("abort_aluout", bus.aluout, 32'd0);
    chk("abort_carry", {31'd0, bus.carry}, 32'd0);
    chk("abort_zero", {31'd0, bus.zero}, 32'd0);
    chk("abort_valid", {31'd0, bus.result_valid}, 32'd0);
    chk("abort_stall", {31'd0, bus.stall}, 32'd0);
    tick;
    reset = 1'b1;
    m_carry = 1'b0;
    v = 0;
    repeat (12) begin
      if (bus.result_valid || bus.stall) v++;
      tick;
    end
    chk("abort_quiet", 32'(v), 32'd0);
    issue("add_after_rst", 1'b0, 1'b1, 3'd1, 3'd0, 32'd2, 32'd3, 5'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
